// File: rtl/commit_mem_fetcher_if.sv
// Purpose : request, AXI-style read channel and load-buffer write bundle of the fill engine.
// Latency : wires only.
// Backpressure: req_ready gates requests; m_arready/m_rvalid pace the bus side.
// Ports   : master = fetcher side (drives AR, rready, load-buffer writes, status);
//           slave  = environment side (requester, bus slave, load buffer).
interface commit_mem_fetcher_if;
  // request side
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        req_uncached;
  logic        rel;
  // read address channel
  logic        m_arvalid;
  logic        m_arready;
  logic [31:0] m_araddr;
  logic [7:0]  m_arlen;
  logic [2:0]  m_arsize;
  logic [1:0]  m_arburst;
  // read data channel
  logic        m_rvalid;
  logic        m_rready;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp;
  logic        m_rlast;
  // load buffer write ports
  logic        lb_wea;
  logic [31:0] lb_addra;
  logic [31:0] lb_dina;
  logic        lb_web;
  logic [31:0] lb_addrb;
  logic [31:0] lb_dinb;
  logic        lb_wec;
  // status
  logic        busy;
  logic        err;

  modport master (
    input  req_valid, req_addr, req_uncached, rel,
    input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    output req_ready, m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    output lb_wea, lb_addra, lb_dina, lb_web, lb_addrb, lb_dinb, lb_wec, busy, err
  );

  modport slave (
    output req_valid, req_addr, req_uncached, rel,
    output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast,
    input  req_ready, m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
    input  lb_wea, lb_addra, lb_dina, lb_web, lb_addrb, lb_dinb, lb_wec, busy, err
  );
endinterface

// File: rtl/commit_mem_fetcher.sv
// Purpose : single-outstanding load-miss fill engine feeding the commit-stage load buffer.
// Latency : AR one cycle after accept; each accepted beat written one cycle later.
// Backpressure: one request at a time; address held until m_arready; rready whenever in R.
// Ports   : clk, resetn (async active-low); bus = commit_mem_fetcher_if.master carrying
//           request/rel, AXI-style read address+data channels, load-buffer write ports, busy/err.
module commit_mem_fetcher #(
  parameter int LINE_WORDS  = 8,
  parameter bit CHECK_RLAST = 1'b1
) (
  input logic                  clk,
  input logic                  resetn,
  commit_mem_fetcher_if.master bus
);
  localparam logic [2:0] LAST_IDX = 3'(LINE_WORDS - 1);
  localparam logic [7:0] LINE_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [2:0] {IDLE, AR, R, HOLD, INV} state_t;

  state_t      state_q, state_d;
  logic        arvalid_q, arvalid_d;
  logic [31:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        unc_q, unc_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        drain_q, drain_d;   // beats past the expected last one are swallowed
  logic        errs_q, errs_d;     // sticky error for the current transaction
  logic        wea_q, wea_d, web_q, web_d, wec_q, wec_d, err_q, err_d;
  logic [31:0] addra_q, addra_d, dina_q, dina_d, addrb_q, addrb_d, dinb_q, dinb_d;

  logic beat, beat_bad, exp_last, mism, beat_fail;
  logic unused_addr_bits;

  assign beat      = (state_q == R) && bus.m_rvalid;
  assign beat_bad  = bus.m_rresp != 2'b00;
  // uncached reads are a single beat; a line ends on index LAST_IDX
  assign exp_last  = unc_q || (cnt_q == LAST_IDX);
  assign mism      = CHECK_RLAST && !drain_q && (bus.m_rlast != exp_last);
  assign beat_fail = beat_bad || mism;

  assign unused_addr_bits = ^bus.req_addr[1:0];

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    arlen_d   = arlen_q;
    unc_d     = unc_q;
    cnt_d     = cnt_q;
    drain_d   = drain_q;
    errs_d    = errs_q;
    wea_d     = 1'b0;
    web_d     = 1'b0;
    wec_d     = 1'b0;
    err_d     = 1'b0;
    addra_d   = addra_q;
    dina_d    = dina_q;
    addrb_d   = addrb_q;
    dinb_d    = dinb_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d   = AR;
          arvalid_d = 1'b1;
          unc_d     = bus.req_uncached;
          cnt_d     = 3'd0;
          drain_d   = 1'b0;
          errs_d    = 1'b0;
          if (bus.req_uncached) begin
            araddr_d = {bus.req_addr[31:2], 2'b00};
            arlen_d  = 8'd0;
          end else begin
            araddr_d = {bus.req_addr[31:5], 5'b0};
            arlen_d  = LINE_LEN;
          end
        end
      end
      AR: begin
        if (bus.m_arready) begin
          arvalid_d = 1'b0;
          state_d   = R;
        end
      end
      R: begin
        if (beat) begin
          err_d  = beat_fail;
          errs_d = errs_q | beat_fail;
          if (!beat_bad && !drain_q) begin
            if (unc_q) begin
              wea_d   = 1'b1;
              addra_d = araddr_q;
              dina_d  = bus.m_rdata;
            end else begin
              web_d   = 1'b1;
              addrb_d = {araddr_q[31:5], cnt_q, 2'b00};
              dinb_d  = bus.m_rdata;
            end
          end
          if (!unc_q) cnt_d = cnt_q + 3'd1;
          if (mism && !bus.m_rlast) drain_d = 1'b1;
          if (bus.m_rlast) begin
            if (unc_q) begin
              state_d = IDLE;
              errs_d  = 1'b0;
            end else if (errs_q || beat_fail) begin
              state_d = INV;
              wec_d   = 1'b1;
            end else begin
              state_d = HOLD;
            end
          end
        end
      end
      HOLD: begin
        if (bus.rel) begin
          state_d = INV;
          wec_d   = 1'b1;
        end
      end
      INV: begin
        state_d = IDLE;
        errs_d  = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= 32'd0;
      arlen_q   <= 8'd0;
      unc_q     <= 1'b0;
      cnt_q     <= 3'd0;
      drain_q   <= 1'b0;
      errs_q    <= 1'b0;
      wea_q     <= 1'b0;
      web_q     <= 1'b0;
      wec_q     <= 1'b0;
      err_q     <= 1'b0;
      addra_q   <= 32'd0;
      dina_q    <= 32'd0;
      addrb_q   <= 32'd0;
      dinb_q    <= 32'd0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      unc_q     <= unc_d;
      cnt_q     <= cnt_d;
      drain_q   <= drain_d;
      errs_q    <= errs_d;
      wea_q     <= wea_d;
      web_q     <= web_d;
      wec_q     <= wec_d;
      err_q     <= err_d;
      addra_q   <= addra_d;
      dina_q    <= dina_d;
      addrb_q   <= addrb_d;
      dinb_q    <= dinb_d;
    end
  end

  assign bus.req_ready = (state_q == IDLE);
  assign bus.m_rready  = (state_q == R);
  assign bus.busy      = (state_q != IDLE);
  assign bus.m_arvalid = arvalid_q;
  assign bus.m_araddr  = araddr_q;
  assign bus.m_arlen   = arlen_q;
  assign bus.m_arsize  = 3'b010;
  assign bus.m_arburst = 2'b01;
  assign bus.lb_wea    = wea_q;
  assign bus.lb_addra  = addra_q;
  assign bus.lb_dina   = dina_q;
  assign bus.lb_web    = web_q;
  assign bus.lb_addrb  = addrb_q;
  assign bus.lb_dinb   = dinb_q;
  assign bus.lb_wec    = wec_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_commit_mem_fetcher.sv
module tb_commit_mem_fetcher;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  commit_mem_fetcher_if bus();

  commit_mem_fetcher #(.LINE_WORDS(8), .CHECK_RLAST(1'b1)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model + monitor ----------------
  logic        m_unc = 1'b0;
  logic [31:0] m_base = 32'd0;
  int          m_idx = 0;
  bit          m_err = 0;
  bit          m_held = 0;
  bit          e_wea = 0, e_web = 0, e_err = 0, e_wec = 0;
  logic [31:0] e_addr = 32'd0, e_dat = 32'd0;
  int acc_cyc = 0, acc_cnt = 0, wea_cnt = 0, web_cnt = 0, wec_cnt = 0, err_cnt = 0;
  int first_web = -1, last_web = -1, wea_lat = -1;

  always @(negedge clk) begin
    if (!resetn) begin
      e_wea = 0; e_web = 0; e_err = 0; e_wec = 0; m_held = 0;
    end else begin
      chk("lb_wea", bus.lb_wea, e_wea);
      chk("lb_web", bus.lb_web, e_web);
      chk("err", bus.err, e_err);
      chk("lb_wec", bus.lb_wec, e_wec);
      if (e_wea) begin
        chk("lb_addra", bus.lb_addra, e_addr);
        chk("lb_dina", bus.lb_dina, e_dat);
      end
      if (e_web) begin
        chk("lb_addrb", bus.lb_addrb, e_addr);
        chk("lb_dinb", bus.lb_dinb, e_dat);
      end
      if (bus.m_arvalid) begin
        chk("m_araddr", bus.m_araddr, m_base);
        chk("m_arlen", bus.m_arlen, m_unc ? 32'd0 : 32'd7);
      end
      if (bus.lb_web) begin
        web_cnt++;
        if (first_web < 0) first_web = cyc - acc_cyc;
        last_web = cyc - acc_cyc;
      end
      if (bus.lb_wea) begin wea_cnt++; wea_lat = cyc - acc_cyc; end
      if (bus.lb_wec) wec_cnt++;
      if (bus.err) err_cnt++;
      // expectations for the next cycle
      e_wea = 0; e_web = 0; e_err = 0; e_wec = 0;
      if (m_held && bus.rel) begin e_wec = 1; m_held = 0; end
      if (bus.m_rvalid && bus.m_rready) begin
        bit bad, over, mism, lastx;
        bad   = bus.m_rresp != 2'b00;
        lastx = m_unc ? (m_idx == 0) : (m_idx == 7);
        over  = m_unc ? (m_idx >= 1) : (m_idx >= 8);
        mism  = !over && (bus.m_rlast != lastx);
        e_err = bad || mism;
        if (bad || mism) m_err = 1;
        if (!bad && !over) begin
          if (m_unc) e_wea = 1; else e_web = 1;
          e_addr = m_unc ? m_base : m_base + 32'(4 * m_idx);
          e_dat  = bus.m_rdata;
        end
        m_idx++;
        if (bus.m_rlast && !m_unc) begin
          if (m_err) e_wec = 1; else m_held = 1;
        end
      end
      if (bus.req_valid && bus.req_ready) begin
        acc_cyc = cyc; acc_cnt++; first_web = -1;
        m_unc  = bus.req_uncached;
        m_base = bus.req_uncached ? {bus.req_addr[31:2], 2'b00} : {bus.req_addr[31:5], 5'b0};
        m_idx  = 0; m_err = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [31:0] addr, input logic unc, input int ar_delay, input bit gap,
                      input int nbeats, input int rlast_at, input int bad_beat,
                      input logic [31:0] d0, input int rst_at);
    int w;
    bus.req_valid = 1'b1; bus.req_addr = addr; bus.req_uncached = unc;
    tick();
    bus.req_valid = 1'b0;
    w = 0;
    while (!bus.m_arvalid && w < 20) begin tick(); w++; end
    if (!bus.m_arvalid) begin chk("arvalid_wait", bus.m_arvalid, 1); return; end
    for (int i = 0; i < ar_delay; i++) tick();
    if (ar_delay > 0) chk("arvalid_held", bus.m_arvalid, 1);
    bus.m_arready = 1'b1;
    tick();
    bus.m_arready = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      if (b == rst_at) begin
        bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0;
        resetn = 1'b0;
        return;
      end
      if (gap) begin bus.m_rvalid = 1'b0; tick(); end
      bus.m_rvalid = 1'b1;
      bus.m_rdata  = d0 + 32'(b);
      bus.m_rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
      bus.m_rlast  = (b == rlast_at);
      tick();
    end
    bus.m_rvalid = 1'b0; bus.m_rlast = 1'b0; bus.m_rresp = 2'b00;
  endtask

  task automatic release_line();
    bus.rel = 1'b1; tick(); bus.rel = 1'b0; tick(); tick();
  endtask

  initial begin
    int s_web, s_wea, s_wec, s_err, s_acc;
    bus.req_valid = 0; bus.req_addr = 0; bus.req_uncached = 0; bus.rel = 0;
    bus.m_arready = 0; bus.m_rvalid = 0; bus.m_rdata = 0; bus.m_rresp = 0; bus.m_rlast = 0;
    #1 resetn = 1'b0;
    #1;
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_busy", bus.busy, 0);
    chk("rst_arvalid", bus.m_arvalid, 0);
    chk("rst_araddr", bus.m_araddr, 0);
    chk("rst_arlen", bus.m_arlen, 0);
    chk("rst_wea_web_wec_err", {bus.lb_wea, bus.lb_web, bus.lb_wec, bus.err}, 0);
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    // uncached single word
    s_wea = wea_cnt;
    chk("t1_req_ready", bus.req_ready, 1);
    fill(32'h1000_0044, 1'b1, 0, 0, 1, 0, -1, 32'hDEAD_BEEF, -1);
    chk("t1_wea", bus.lb_wea, 1);
    chk("t1_addra", bus.lb_addra, 32'h1000_0044);
    chk("t1_dina", bus.lb_dina, 32'hDEAD_BEEF);
    chk("t1_busy", bus.busy, 0);
    chk("t1_next_ready", bus.req_ready, 1);
    chk("t1_araddr", bus.m_araddr, 32'h1000_0044);
    chk("t1_arlen", bus.m_arlen, 0);
    tick();
    chk("t1_wea_lat", wea_lat, 3);
    chk("t1_wea_cnt", wea_cnt - s_wea, 1);
    chk("t1_wea_drop", bus.lb_wea, 0);

    // cached line fill, best case
    s_web = web_cnt;
    fill(32'h8000_1234, 1'b0, 0, 0, 8, 7, -1, 32'h0000_00A0, -1);
    chk("t2_araddr", bus.m_araddr, 32'h8000_1220);
    chk("t2_arlen", bus.m_arlen, 7);
    chk("t2_arsize", bus.m_arsize, 3'b010);
    chk("t2_arburst", bus.m_arburst, 2'b01);
    chk("t2_last_addrb", bus.lb_addrb, 32'h8000_123C);
    chk("t2_last_dinb", bus.lb_dinb, 32'h0000_00A7);
    chk("t2_hold_ready", bus.req_ready, 0);
    tick();
    chk("t2_web_cnt", web_cnt - s_web, 8);
    chk("t2_first_web", first_web, 3);
    chk("t2_last_web", last_web, 10);
    tick();
    chk("t2_still_hold", bus.req_ready, 0);
    chk("t2_busy", bus.busy, 1);

    // release with a competing request, then rel in IDLE
    s_wec = wec_cnt; s_acc = acc_cnt;
    bus.rel = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 32'h55;
    tick();
    bus.rel = 1'b0; bus.req_valid = 1'b0;
    chk("t3_wec", bus.lb_wec, 1);
    chk("t3_inv_ready", bus.req_ready, 0);
    tick();
    chk("t3_wec_drop", bus.lb_wec, 0);
    chk("t3_idle_ready", bus.req_ready, 1);
    chk("t3_wec_cnt", wec_cnt - s_wec, 1);
    chk("t3_no_accept", acc_cnt - s_acc, 0);
    s_wec = wec_cnt;
    bus.rel = 1'b1; repeat (3) tick(); bus.rel = 1'b0; tick();
    chk("t3_idle_rel", wec_cnt - s_wec, 0);

    // slow arready, gapped data
    s_web = web_cnt; s_err = err_cnt;
    fill(32'h0000_2008, 1'b0, 5, 1, 8, 7, -1, 32'h0000_0100, -1);
    tick();
    chk("t4_web_cnt", web_cnt - s_web, 8);
    chk("t4_err_cnt", err_cnt - s_err, 0);
    chk("t4_araddr", bus.m_araddr, 32'h0000_2000);
    chk("t4_hold", bus.req_ready, 0);
    release_line();

    // error response on beat 3
    s_web = web_cnt; s_err = err_cnt; s_wec = wec_cnt;
    fill(32'h3000_0040, 1'b0, 0, 0, 8, 7, 3, 32'h0000_0300, -1);
    chk("t5_wec", bus.lb_wec, 1);
    tick();
    chk("t5_idle", bus.req_ready, 1);
    chk("t5_web_cnt", web_cnt - s_web, 7);
    chk("t5_err_cnt", err_cnt - s_err, 1);
    chk("t5_wec_cnt", wec_cnt - s_wec, 1);

    // rlast arrives early (after 5 beats)
    s_web = web_cnt; s_err = err_cnt; s_wec = wec_cnt;
    fill(32'h4000_0000, 1'b0, 0, 0, 5, 4, -1, 32'h0000_0400, -1);
    tick();
    chk("t6_idle", bus.req_ready, 1);
    chk("t6_web_cnt", web_cnt - s_web, 5);
    chk("t6_err_cnt", err_cnt - s_err, 1);
    chk("t6_wec_cnt", wec_cnt - s_wec, 1);

    // rlast missing on the 8th beat: two extra beats drained
    s_web = web_cnt; s_err = err_cnt; s_wec = wec_cnt;
    fill(32'h5000_0020, 1'b0, 0, 0, 10, 9, -1, 32'h0000_0500, -1);
    tick();
    chk("t7_idle", bus.req_ready, 1);
    chk("t7_web_cnt", web_cnt - s_web, 8);
    chk("t7_err_cnt", err_cnt - s_err, 1);
    chk("t7_wec_cnt", wec_cnt - s_wec, 1);

    // uncached with error response
    s_wea = wea_cnt; s_err = err_cnt; s_wec = wec_cnt;
    fill(32'h0000_0013, 1'b1, 0, 0, 1, 0, 0, 32'h1111_2222, -1);
    tick();
    chk("t8_wea_cnt", wea_cnt - s_wea, 0);
    chk("t8_err_cnt", err_cnt - s_err, 1);
    chk("t8_wec_cnt", wec_cnt - s_wec, 0);
    chk("t8_idle", bus.req_ready, 1);

    // async reset in the middle of a burst
    fill(32'h8000_1234, 1'b0, 0, 0, 8, 7, -1, 32'h0000_00B0, 4);
    #1;
    chk("t9_arvalid", bus.m_arvalid, 0);
    chk("t9_araddr", bus.m_araddr, 0);
    chk("t9_arlen", bus.m_arlen, 0);
    chk("t9_strobes", {bus.lb_wea, bus.lb_web, bus.lb_wec, bus.err}, 0);
    chk("t9_addrb", bus.lb_addrb, 0);
    chk("t9_dinb", bus.lb_dinb, 0);
    chk("t9_addra_dina", bus.lb_addra | bus.lb_dina, 0);
    chk("t9_busy", bus.busy, 0);
    chk("t9_rready", bus.m_rready, 0);
    chk("t9_req_ready", bus.req_ready, 1);
    tick(); tick();
    resetn = 1'b1;
    tick();
    s_wea = wea_cnt;
    fill(32'h2000_0008, 1'b1, 0, 0, 1, 0, -1, 32'hCAFE_F00D, -1);
    chk("t9_post_dina", bus.lb_dina, 32'hCAFE_F00D);
    tick();
    chk("t9_post_wea", wea_cnt - s_wea, 1);
    s_web = web_cnt;
    fill(32'h8000_1234, 1'b0, 0, 0, 8, 7, -1, 32'h0000_00C0, -1);
    tick();
    chk("t9_post_web", web_cnt - s_web, 8);
    release_line();
    chk("t9_final_idle", bus.req_ready, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    failures++;
    $display("FAIL timeout simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/commit_mem_fetcher.md
Name: commit_mem_fetcher

Overview:
Bus-side fill engine that produces the write traffic consumed by the commit-stage load buffer.
- Accepts one load-miss request at a time.
- Issues an AXI-style read, either a single-word uncached read or a 32-byte INCR line burst.
- Drives each returned beat onto the load buffer uncached write port (wea/addra/dina) or line write port (web/addrb/dinb).
- Holds a cached line resident until released, then clears it with wec.

Parameters:
LINE_WORDS, 8, words per cached line; fixed at 8 because the buffer indexes by addr[4:2].
CHECK_RLAST, 1, when 1 a beat-count/rlast mismatch raises err.

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
req_valid  in  1  load-miss request
req_ready  out  1  fetcher can accept a request
req_addr  in  32  byte address of the missing load
req_uncached  in  1  1 = single-word uncached read; 0 = line fill
rel  in  1  line consumed/installed; release buffer contents
m_arvalid  out  1  read address valid
m_arready  in  1  read address accepted
m_araddr  out  32  read address
m_arlen  out  8  burst length minus one (0 or 7)
m_arsize  out  3  constant 3'b010
m_arburst  out  2  constant 2'b01 (INCR)
m_rvalid  in  1  read data valid
m_rready  out  1  read data ready
m_rdata  in  32  read data
m_rresp  in  2  read response (nonzero = error)
m_rlast  in  1  last beat
lb_wea  out  1  load buffer uncached write strobe
lb_addra  out  32  uncached address
lb_dina  out  32  uncached data
lb_web  out  1  load buffer line write strobe
lb_addrb  out  32  line word address
lb_dinb  out  32  line word data
lb_wec  out  1  load buffer line invalidate
busy  out  1  state != IDLE
err  out  1  one-cycle error pulse

Behaviour:
- FSM states: IDLE, AR, R, HOLD, INV. All transitions and outputs are registered except req_ready, m_rready and busy, which decode state.
- Reset (async, resetn=0):
  - state=IDLE.
  - m_arvalid, lb_wea, lb_web, lb_wec and err = 0.
  - m_araddr, m_arlen, lb_addr* and lb_din* = 0.
  - Beat counter = 0.
- Reset asserted mid-burst abandons the transaction. The bus slave must be reset in the same domain.
- IDLE:
  - req_ready=1.
  - On req_valid, latch the request and go to AR.
  - Uncached: m_araddr={req_addr[31:2],2'b00}, m_arlen=0.
  - Cached: m_araddr={req_addr[31:5],5'b0}, m_arlen=7.
  - rel is ignored in IDLE.
- AR:
  - m_arvalid=1, with address and length stable until m_arready.
  - On handshake, go to R. m_arvalid drops the next cycle.
- R:
  - m_rready=1.
  - A beat is accepted on m_rvalid&m_rready in cycle N. In cycle N+1 it appears as a single-cycle strobe:
    - uncached: lb_wea=1, lb_addra=latched word address, lb_dina=rdata;
    - cached: lb_web=1, lb_addrb={base[31:5],cnt[2:0],2'b00}, lb_dinb=rdata.
  - The 3-bit beat counter increments per cached beat and wraps 7→0.
  - Beats with m_rresp!=0 produce no write strobe, set the sticky error flag and pulse err in N+1.
  - Termination is on the beat with m_rlast:
    - uncached → IDLE;
    - cached, no error → HOLD;
    - cached with error → INV.
  - With CHECK_RLAST=1, a mismatch counts as an error (cached → INV):
    - rlast before the 8th beat;
    - 8th beat without rlast, in which case further beats are drained until rlast and not written.
- HOLD:
  - req_ready=0; line stays valid in the buffer.
  - On rel, go to INV. A simultaneous req_valid is not accepted.
- INV: lb_wec=1 for exactly one cycle, then IDLE with the error flag cleared.
- Latency, cached best case:
  - accept at cycle 0; m_arvalid in cycle 1;
  - arready in cycle 1; beats in cycles 2–9;
  - lb_web in cycles 3–10; HOLD reached in cycle 10.
- Latency, uncached best case: lb_wea in cycle 3; IDLE in cycle 3; next request accepted in cycle 3.
- Back-to-back requests are never overlapped; at most one outstanding read.

Test Plan:
- Uncached 0x1000_0044, arready immediate, rdata=0xDEADBEEF → araddr=0x1000_0044, arlen=0; lb_wea one cycle with addra=0x1000_0044, dina=0xDEADBEEF; busy low next cycle.
- Cached 0x8000_1234, rdata=0xA0+i for i=0..7 → araddr=0x8000_1220, arlen=7; 8 lb_web pulses, addrb 0x8000_1220..0x8000_123C, data 0xA0..0xA7; state HOLD, req_ready=0.
- rel in HOLD → exactly one lb_wec pulse the next cycle, then req_ready=1; rel in IDLE → no wec.
- arready held low 5 cycles, rvalid gapped every other cycle → m_araddr/arlen stable throughout; writes follow each accepted beat by 1 cycle, with no write on gaps.
- Cached fill with rresp=2'b10 on beat 3 → no web for beat 3; err pulse; after rlast, lb_wec pulse and return to IDLE without rel.
- resetn low at beat 4 of a burst → all outputs 0 immediately (async); state IDLE; a subsequent request completes normally.
